// File: rtl/gx4000_asic_ram_arbiter.sv
// gx4000_asic_ram_arbiter
// Single-port access controller for the 16 KB Plus ASIC RAM. One RAM access
// per clk_sys cycle, shared between the CPU page window, video sprite/palette
// fetch and the three sound DMA channels.
//   Slot priority: starved CPU > video > CPU > DMA round-robin.
//   While the ASIC is locked (plus_mode=0 or asic_valid=0), CPU requests are
//   acknowledged at once without using the RAM: writes vanish and reads
//   return 0xFF.
// Optional feature macro: GX4000_ASIC_DMA_EN. When it is defined, the DMA
// round-robin arbiter is built. When it is undefined, the DMA outputs are
// tied to zero.
module gx4000_asic_ram_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int AW           = 14
) (
   input  logic            clk_sys,
   input  logic            reset_n,
   input  logic            plus_mode,
   input  logic            asic_valid,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [AW-1:0]   cpu_addr,
   input  logic [7:0]      cpu_wdata,
   output logic            cpu_gnt,
   output logic            cpu_rvalid,
   output logic [7:0]      cpu_rdata,
   input  logic            vid_req,
   input  logic [AW-1:0]   vid_addr,
   output logic            vid_gnt,
   output logic            vid_rvalid,
   output logic [7:0]      vid_rdata,
   input  logic [2:0]      dma_req,
   input  logic [3*AW-1:0] dma_addr,
   output logic [2:0]      dma_gnt,
   output logic [2:0]      dma_rvalid,
   output logic [7:0]      dma_rdata,
   output logic [AW-1:0]   ram_addr,
   output logic            ram_rd,
   output logic            ram_wr,
   output logic [7:0]      ram_din,
   input  logic [7:0]      ram_q
);

   // Wait counter width; keep at least one bit so a disabled override still elaborates
   localparam int              WCW        = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [WCW-1:0]  STARVE_MAX = WCW'(STARVE_LIMIT);

   logic           unlocked_s;
   logic           cpu_ram_req_s;
   logic           vid_ok_s;
   logic           starve_s;
   logic           cpu_lock_gnt_s;
   logic           cpu_win_s;
   logic           vid_win_s;
   logic [2:0]     dma_win_s;
   logic [2:0]     dma_pick_s;
   logic [AW-1:0]  dma_sel_addr_s;

   logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
   logic           cpu_rvalid_q, cpu_rvalid_d;
   logic           cpu_lock_rd_q, cpu_lock_rd_d;
   logic           vid_rvalid_q, vid_rvalid_d;

   assign unlocked_s     = plus_mode & asic_valid;
   assign cpu_ram_req_s  = cpu_req & unlocked_s;
   assign vid_ok_s       = vid_req & plus_mode;
   assign starve_s       = (STARVE_LIMIT != 0) && (wait_cnt_q == STARVE_MAX);
   // A locked CPU access never touches RAM, so it is acknowledged immediately
   assign cpu_lock_gnt_s = reset_n & cpu_req & ~unlocked_s;

`ifdef GX4000_ASIC_DMA_EN
   logic [1:0] rr_ptr_q, rr_ptr_d;

   // Round-robin pick among eligible DMA channels, starting at rr_ptr
   always_comb begin
      logic [2:0] elig;
      elig       = plus_mode ? dma_req : 3'b000;
      dma_pick_s = 3'b000;
      case (rr_ptr_q)
         2'd1: begin
            if (elig[1])      dma_pick_s = 3'b010;
            else if (elig[2]) dma_pick_s = 3'b100;
            else if (elig[0]) dma_pick_s = 3'b001;
            else              dma_pick_s = 3'b000;
         end
         2'd2: begin
            if (elig[2])      dma_pick_s = 3'b100;
            else if (elig[0]) dma_pick_s = 3'b001;
            else if (elig[1]) dma_pick_s = 3'b010;
            else              dma_pick_s = 3'b000;
         end
         default: begin
            if (elig[0])      dma_pick_s = 3'b001;
            else if (elig[1]) dma_pick_s = 3'b010;
            else if (elig[2]) dma_pick_s = 3'b100;
            else              dma_pick_s = 3'b000;
         end
      endcase
   end

   // Address of the granted DMA channel
   always_comb begin
      case (dma_win_s)
         3'b001:  dma_sel_addr_s = dma_addr[0 +: AW];
         3'b010:  dma_sel_addr_s = dma_addr[AW +: AW];
         3'b100:  dma_sel_addr_s = dma_addr[2*AW +: AW];
         default: dma_sel_addr_s = {AW{1'b0}};
      endcase
   end

   // Advance the pointer past the channel just served; hold otherwise
   always_comb begin
      case (dma_win_s)
         3'b001:  rr_ptr_d = 2'd1;
         3'b010:  rr_ptr_d = 2'd2;
         3'b100:  rr_ptr_d = 2'd0;
         default: rr_ptr_d = rr_ptr_q;
      endcase
   end

   // Round-robin pointer and DMA read-return flags
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q   <= 2'd0;
         dma_rvalid <= 3'b000;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         dma_rvalid <= dma_win_s;
      end
   end

   assign dma_gnt   = dma_win_s;
   assign dma_rdata = ram_q;
`else
   logic unused_dma_s;
   assign unused_dma_s   = ^{dma_req, dma_addr};
   assign dma_pick_s     = 3'b000;
   assign dma_sel_addr_s = {AW{1'b0}};
   assign dma_gnt        = 3'b000;
   assign dma_rvalid     = 3'b000;
   assign dma_rdata      = 8'h00;
`endif

   // Fixed-priority selection of the single RAM slot owner
   always_comb begin
      cpu_win_s = 1'b0;
      vid_win_s = 1'b0;
      dma_win_s = 3'b000;
      if (!reset_n) begin
         cpu_win_s = 1'b0;
      end else if (cpu_ram_req_s && starve_s) begin
         cpu_win_s = 1'b1;
      end else if (vid_ok_s) begin
         vid_win_s = 1'b1;
      end else if (cpu_ram_req_s) begin
         cpu_win_s = 1'b1;
      end else begin
         dma_win_s = dma_pick_s;
      end
   end

   // Drive the RAM port from the slot owner; idle when nobody wins
   always_comb begin
      ram_addr = {AW{1'b0}};
      ram_rd   = 1'b0;
      ram_wr   = 1'b0;
      ram_din  = 8'h00;
      if (cpu_win_s) begin
         ram_addr = cpu_addr;
         ram_rd   = ~cpu_we;
         ram_wr   = cpu_we;
         ram_din  = cpu_wdata;
      end else if (vid_win_s) begin
         ram_addr = vid_addr;
         ram_rd   = 1'b1;
      end else if (|dma_win_s) begin
         ram_addr = dma_sel_addr_s;
         ram_rd   = 1'b1;
      end else begin
         ram_rd   = 1'b0;
      end
   end

   // Next-state for the starvation counter and the CPU/video read returns
   always_comb begin
      if (!cpu_req || cpu_gnt) begin
         wait_cnt_d = {WCW{1'b0}};
      end else if (wait_cnt_q != STARVE_MAX) begin
         wait_cnt_d = wait_cnt_q + WCW'(1);
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
      cpu_rvalid_d  = cpu_gnt & ~cpu_we;
      // Locked status is captured at grant time, so a later lock does not corrupt a real read
      cpu_lock_rd_d = cpu_lock_gnt_s & ~cpu_we;
      vid_rvalid_d  = vid_win_s;
   end

   // State registers; reset discards any in-flight read
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q    <= {WCW{1'b0}};
         cpu_rvalid_q  <= 1'b0;
         cpu_lock_rd_q <= 1'b0;
         vid_rvalid_q  <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         cpu_rvalid_q  <= cpu_rvalid_d;
         cpu_lock_rd_q <= cpu_lock_rd_d;
         vid_rvalid_q  <= vid_rvalid_d;
      end
   end

   assign cpu_gnt    = cpu_win_s | cpu_lock_gnt_s;
   assign vid_gnt    = vid_win_s;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_lock_rd_q ? 8'hFF : ram_q;
   assign vid_rvalid = vid_rvalid_q;
   assign vid_rdata  = ram_q;

endmodule

// File: tb/tb_gx4000_asic_ram_arbiter.sv
// Scoreboard bench for gx4000_asic_ram_arbiter: the stimulus checks the
// same-cycle grants and queues the expected read data. A monitor pops the
// queue and compares on every rvalid. Build with or without
// GX4000_ASIC_DMA_EN; the same macro selects which DMA checks run.
module tb_gx4000_asic_ram_arbiter;
   localparam int AW = 14;

   logic            clk_sys = 1'b0;
   logic            reset_n;
   logic            plus_mode, asic_valid;
   logic            cpu_req, cpu_we;
   logic [AW-1:0]   cpu_addr;
   logic [7:0]      cpu_wdata;
   logic            cpu_gnt, cpu_rvalid;
   logic [7:0]      cpu_rdata;
   logic            vid_req;
   logic [AW-1:0]   vid_addr;
   logic            vid_gnt, vid_rvalid;
   logic [7:0]      vid_rdata;
   logic [2:0]      dma_req;
   logic [3*AW-1:0] dma_addr;
   logic [2:0]      dma_gnt, dma_rvalid;
   logic [7:0]      dma_rdata;
   logic [AW-1:0]   ram_addr;
   logic            ram_rd, ram_wr;
   logic [7:0]      ram_din;
   logic [7:0]      ram_q;

   logic [7:0]      mem [0:(1<<AW)-1];
   int              tests = 0;
   int              fails = 0;
   int              wr_pulses = 0;
   logic [7:0]      cpu_q [$];
   logic [7:0]      vid_q [$];
   logic [10:0]     dma_q [$];

   always #5 clk_sys = ~clk_sys;

   gx4000_asic_ram_arbiter #(.STARVE_LIMIT(4), .AW(AW)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .plus_mode(plus_mode), .asic_valid(asic_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
      .vid_rdata(vid_rdata), .dma_req(dma_req), .dma_addr(dma_addr), .dma_gnt(dma_gnt),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .ram_addr(ram_addr), .ram_rd(ram_rd),
      .ram_wr(ram_wr), .ram_din(ram_din), .ram_q(ram_q)
   );

   // RAM model with registered read data and a write-strobe counter
   always @(posedge clk_sys) begin
      if (ram_wr) begin
         mem[ram_addr] <= ram_din;
         wr_pulses     <= wr_pulses + 1;
      end
      if (ram_rd) ram_q <= mem[ram_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Monitor: compare every read return against the scoreboard; single-grant invariant
   always @(negedge clk_sys) begin
      if (cpu_rvalid) begin
         if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
         else                   check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
      end
      if (vid_rvalid) begin
         if (vid_q.size() == 0) check("vid_rvalid_unexpected", 32'(vid_rvalid), 32'd0);
         else                   check("vid_rdata", 32'(vid_rdata), 32'(vid_q.pop_front()));
      end
      if (|dma_rvalid) begin
         if (dma_q.size() == 0) check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
         else                   check("dma_rvalid_rdata", 32'({dma_rvalid, dma_rdata}), 32'(dma_q.pop_front()));
      end
      if (reset_n && plus_mode && asic_valid)
         check("one_grant", 32'($countones({cpu_gnt, vid_gnt, dma_gnt}) <= 1), 32'd1);
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0] ^ 8'hA5;
      ram_q = 8'h00;
      reset_n = 1'b0; plus_mode = 1'b1; asic_valid = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0000; cpu_wdata = 8'h00;
      vid_req = 1'b1; vid_addr = 14'h0000;
      dma_req = 3'b111; dma_addr = {14'h0302, 14'h0201, 14'h0100};

      // Reset: no grants, RAM idle, no returns even with everyone requesting
      repeat (2) @(negedge clk_sys);
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_vid_gnt", 32'(vid_gnt), 32'd0);
      check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
      check("rst_ram_rd",  32'(ram_rd), 32'd0);
      check("rst_rvalid",  32'({cpu_rvalid, vid_rvalid, dma_rvalid}), 32'd0);
      tick();
      reset_n = 1'b1; cpu_req = 1'b0; vid_req = 1'b0; dma_req = 3'b000;

      // Unlocked CPU write 0x5A to 0x0123 then read it back
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'h5A;
      @(negedge clk_sys);
      check("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
      check("wr_ram_wr",  32'({ram_wr, ram_rd}), 32'b10);
      check("wr_ram_addr", 32'(ram_addr), 32'h0123);
      check("wr_ram_din", 32'(ram_din), 32'h5A);
      tick();
      cpu_we = 1'b0;
      @(negedge clk_sys);
      check("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
      check("rd_ram_rd",  32'({ram_wr, ram_rd}), 32'b01);
      cpu_q.push_back(8'h5A);
      tick();
      cpu_req = 1'b0;
      @(negedge clk_sys);
      check("wr_pulse_count", 32'(wr_pulses), 32'd1);

      // Starvation: continuous video, CPU read from cycle 0 wins on cycle 4
      tick();
      vid_req = 1'b1; vid_addr = 14'h2000; cpu_req = 1'b1; cpu_addr = 14'h0123;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_sys);
         check("starve_vid_gnt", 32'({vid_gnt, cpu_gnt}), 32'b10);
         vid_q.push_back(8'hA5);
         tick();
      end
      @(negedge clk_sys);
      check("starve_cpu_gnt", 32'({vid_gnt, cpu_gnt}), 32'b01);
      cpu_q.push_back(8'h5A);
      tick();
      cpu_req = 1'b0;
      @(negedge clk_sys);
      check("starve_vid_resume", 32'({vid_gnt, cpu_gnt}), 32'b10);
      vid_q.push_back(8'hA5);
      tick();
      vid_req = 1'b0;

`ifdef GX4000_ASIC_DMA_EN
      // All three DMA channels requesting: round-robin 001,010,100,001
      dma_req = 3'b111;
      for (int c = 0; c < 4; c++) begin
         logic [2:0] eg;
         logic [7:0] ed;
         case (c)
            1:       begin eg = 3'b010; ed = 8'hA4; end
            2:       begin eg = 3'b100; ed = 8'hA7; end
            default: begin eg = 3'b001; ed = 8'hA5; end
         endcase
         @(negedge clk_sys);
         check("dma_rr_gnt", 32'(dma_gnt), 32'(eg));
         check("dma_ram_rd", 32'(ram_rd), 32'd1);
         dma_q.push_back({eg, ed});
         tick();
      end
      dma_req = 3'b000;
`else
      // DMA compiled out: requests are ignored and RAM stays idle
      dma_req = 3'b111;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_sys);
         check("nodma_gnt", 32'({dma_gnt, dma_rvalid}), 32'd0);
         check("nodma_ram_idle", 32'({ram_rd, ram_wr}), 32'd0);
         check("nodma_rdata", 32'(dma_rdata), 32'd0);
         tick();
      end
      dma_req = 3'b000;
`endif

      // Locked: write dropped, read returns 0xFF; after unlock the old value remains
      asic_valid = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0010; cpu_wdata = 8'h77;
      @(negedge clk_sys);
      check("lock_wr_gnt", 32'({cpu_gnt, ram_wr}), 32'b10);
      tick();
      cpu_we = 1'b0;
      @(negedge clk_sys);
      check("lock_rd_gnt", 32'({cpu_gnt, ram_rd}), 32'b10);
      cpu_q.push_back(8'hFF);
      tick();
      asic_valid = 1'b1;
      @(negedge clk_sys);
      check("unlock_rd_gnt", 32'({cpu_gnt, ram_rd}), 32'b11);
      cpu_q.push_back(8'hB5);
      tick();
      cpu_req = 1'b0;
      @(negedge clk_sys);
      check("lock_no_write", 32'(wr_pulses), 32'd1);
      tick();

      // Reset after a video grant discards the return and clears wait_cnt/rr_ptr
      vid_req = 1'b1; vid_addr = 14'h2001; cpu_req = 1'b1; cpu_addr = 14'h0123;
      @(negedge clk_sys);
      check("pre_rst_vid_gnt", 32'(vid_gnt), 32'd1);
      vid_q.push_back(8'hA4);
      tick();
      @(negedge clk_sys);
      check("pre_rst_vid_gnt2", 32'(vid_gnt), 32'd1);
      reset_n = 1'b0;
      #1;
      check("in_rst_gnts", 32'({cpu_gnt, vid_gnt, ram_rd}), 32'd0);
      @(posedge clk_sys);
      #1;
      check("in_rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_sys);
         check("post_rst_vid_gnt", 32'({vid_gnt, cpu_gnt}), 32'b10);
         vid_q.push_back(8'hA4);
         tick();
      end
      @(negedge clk_sys);
      check("post_rst_cpu_gnt", 32'({vid_gnt, cpu_gnt}), 32'b01);
      cpu_q.push_back(8'h5A);
      tick();
      cpu_req = 1'b0; vid_req = 1'b0;
`ifdef GX4000_ASIC_DMA_EN
      dma_req = 3'b111;
      @(negedge clk_sys);
      check("post_rst_dma_first", 32'(dma_gnt), 32'b001);
      dma_q.push_back({3'b001, 8'hA5});
      tick();
      dma_req = 3'b000;
`endif

      repeat (3) tick();
      check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
      check("vid_q_drained", 32'(vid_q.size()), 32'd0);
      check("dma_q_drained", 32'(dma_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
